// File: rtl/pds_port_seq.sv
// Power-stage sequencer: staggers per-port soft-start through a single shared ramp slot,
// filters overcurrent in ON, and holds faulted ports in a cooldown that keeps them dropped.
module pds_port_seq #(
  parameter int NUM_PORTS  = 4,
  parameter int INRUSH_CYC = 16,
  parameter int OC_FILT    = 4,
  parameter int COOL_CYC   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] on_req,
  input  logic [NUM_PORTS-1:0] oc,
  output logic [NUM_PORTS-1:0] pwr_en,
  output logic [NUM_PORTS-1:0] pwr_good,
  output logic [NUM_PORTS-1:0] off,
  output logic [NUM_PORTS-1:0] fault,
  output logic                 busy
);

  localparam int RW = $clog2(INRUSH_CYC + 1);
  localparam int OW = $clog2(OC_FILT + 1);
  localparam int CW = $clog2(COOL_CYC + 1);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAIT,
    ST_RAMP,
    ST_ON,
    ST_FAULT
  } state_e;

  state_e          state_q [NUM_PORTS];
  state_e          state_d [NUM_PORTS];
  logic [OW-1:0]   oc_cnt_q [NUM_PORTS];
  logic [OW-1:0]   oc_cnt_d [NUM_PORTS];
  logic [CW-1:0]   cool_q [NUM_PORTS];
  logic [CW-1:0]   cool_d [NUM_PORTS];
  logic [RW-1:0]   ramp_cnt_q;
  logic [RW-1:0]   ramp_cnt_d;

  logic            rbusy;
  logic            grant;
  logic            ramp_done;
  logic [OW-1:0]   oc_next;

  // rbusy decodes the registered states, so a port leaving RAMP still blocks entry on that edge.
  always_comb begin
    rbusy = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (state_q[i] == ST_RAMP) rbusy = 1'b1;
    end
  end

  assign ramp_done = (ramp_cnt_q == '0);

  always_comb begin
    grant   = 1'b0;
    oc_next = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      state_d[i]  = state_q[i];
      oc_cnt_d[i] = '0;
      cool_d[i]   = '0;
      case (state_q[i])
        ST_OFF: begin
          if (on_req[i]) state_d[i] = ST_WAIT;
        end
        ST_WAIT: begin
          if (!on_req[i]) begin
            state_d[i] = ST_OFF;
          end else if (!rbusy && !grant) begin
            state_d[i] = ST_RAMP;
            grant      = 1'b1;
          end
        end
        ST_RAMP: begin
          if (!on_req[i])     state_d[i] = ST_OFF;
          else if (ramp_done) state_d[i] = ST_ON;
        end
        ST_ON: begin
          if (!oc[i])                             oc_next = '0;
          else if (oc_cnt_q[i] == OW'(OC_FILT))   oc_next = oc_cnt_q[i];
          else                                    oc_next = oc_cnt_q[i] + OW'(1);
          if (oc_next == OW'(OC_FILT)) begin
            state_d[i] = ST_FAULT;
            cool_d[i]  = CW'(COOL_CYC - 1);
          end else if (!on_req[i]) begin
            state_d[i] = ST_OFF;
          end else begin
            oc_cnt_d[i] = oc_next;
          end
        end
        ST_FAULT: begin
          if (cool_q[i] == '0) state_d[i] = ST_OFF;
          else                 cool_d[i]  = cool_q[i] - CW'(1);
        end
        default: state_d[i] = ST_OFF;
      endcase
    end
  end

  always_comb begin
    ramp_cnt_d = ramp_cnt_q;
    if (grant)                   ramp_cnt_d = RW'(INRUSH_CYC - 1);
    else if (rbusy && !ramp_done) ramp_cnt_d = ramp_cnt_q - RW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_cnt_q <= '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        state_q[i]  <= ST_OFF;
        oc_cnt_q[i] <= '0;
        cool_q[i]   <= '0;
      end
    end else begin
      ramp_cnt_q <= ramp_cnt_d;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        state_q[i]  <= state_d[i];
        oc_cnt_q[i] <= oc_cnt_d[i];
        cool_q[i]   <= cool_d[i];
      end
    end
  end

  always_comb begin
    pwr_en   = '0;
    pwr_good = '0;
    off      = '0;
    fault    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      pwr_en[i]   = (state_q[i] == ST_RAMP) || (state_q[i] == ST_ON);
      pwr_good[i] = (state_q[i] == ST_ON);
      off[i]      = (state_q[i] == ST_FAULT);
      fault[i]    = (state_q[i] == ST_FAULT);
    end
  end

  assign busy = rbusy;

endmodule

// File: tb/tb_pds_port_seq.sv
// Directed bench for pds_port_seq: ramp latency, stagger order, oc filtering, cooldown,
// ramp abandon hand-over and asynchronous reset.
module tb_pds_port_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] on_req;
  logic [3:0] oc;
  logic [3:0] pwr_en;
  logic [3:0] pwr_good;
  logic [3:0] off;
  logic [3:0] fault;
  logic       busy;

  int n_assert;
  int n_fail;

  pds_port_seq #(
    .NUM_PORTS (4),
    .INRUSH_CYC(16),
    .OC_FILT   (4),
    .COOL_CYC  (64)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .on_req  (on_req),
    .oc      (oc),
    .pwr_en  (pwr_en),
    .pwr_good(pwr_good),
    .off     (off),
    .fault   (fault),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] e_en, input logic [3:0] e_good,
                     input logic [3:0] e_off, input logic [3:0] e_fault, input logic e_busy);
    logic [16:0] obs;
    logic [16:0] exp;
    obs = {busy, fault, off, pwr_good, pwr_en};
    exp = {e_busy, e_fault, e_off, e_good, e_en};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed busy/fault/off/good/en=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    on_req   = '0;
    oc       = '0;
    #2;
    chk("reset_async", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(3);
    chk("reset_hold", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    step(2);
    chk("idle", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // single port ramp latency
    on_req = 4'b0001;
    step(1);
    chk("p0_wait", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1);
    chk("p0_ramp_start", 4'h1, 4'h0, 4'h0, 4'h0, 1'b1);
    step(15);
    chk("p0_ramp_last", 4'h1, 4'h0, 4'h0, 4'h0, 1'b1);
    step(1);
    chk("p0_on", 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);

    // oc filter: three samples is not a fault
    oc = 4'b0001;
    step(3);
    chk("oc3_no_fault", 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    oc = 4'b0000;
    step(1);
    chk("oc_cleared", 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    oc = 4'b0001;
    step(3);
    chk("oc3_again", 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    step(1);
    chk("oc4_fault", 4'h0, 4'h0, 4'h1, 4'h1, 1'b0);
    oc = 4'b0000;

    // cooldown with on_req still held
    step(63);
    chk("cool_last", 4'h0, 4'h0, 4'h1, 4'h1, 1'b0);
    step(1);
    chk("cool_done_off", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1);
    chk("reentry_wait", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1);
    chk("reentry_ramp", 4'h1, 4'h0, 4'h0, 4'h0, 1'b1);
    on_req = 4'b0000;
    step(1);
    chk("p0_abandon", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // two simultaneous requests served in index order with a one-cycle gap
    on_req = 4'b1010;
    step(1);
    chk("p13_wait", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1);
    chk("p1_ramp", 4'h2, 4'h0, 4'h0, 4'h0, 1'b1);
    step(15);
    chk("p1_ramp_last", 4'h2, 4'h0, 4'h0, 4'h0, 1'b1);
    step(1);
    chk("p1_on_gap", 4'h2, 4'h2, 4'h0, 4'h0, 1'b0);
    step(1);
    chk("p3_ramp", 4'hA, 4'h2, 4'h0, 4'h0, 1'b1);
    step(4);
    chk("p3_mid_ramp", 4'hA, 4'h2, 4'h0, 4'h0, 1'b1);

    // asynchronous reset mid-ramp
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    on_req = 4'b0000;
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("post_reset_off", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // ramp abandon hands the slot to a waiting port one edge later
    on_req = 4'b0100;
    step(2);
    chk("p2_ramp", 4'h4, 4'h0, 4'h0, 4'h0, 1'b1);
    on_req = 4'b1100;
    step(4);
    chk("p2_ramp_c5", 4'h4, 4'h0, 4'h0, 4'h0, 1'b1);
    on_req = 4'b1000;
    step(1);
    chk("p2_dropped", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1);
    chk("p3_takes_slot", 4'h8, 4'h0, 4'h0, 4'h0, 1'b1);
    step(16);
    chk("p3_on", 4'h8, 4'h8, 4'h0, 4'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
